led_event_blinker: RTL and testbench
====================================

// Module: led_event_blinker
// PURPOSE
//  Output-side counterpart of the button input path: turns 1-clk event strobes (debounced
//  button presses, counter wrap events) into human-visible LED blinks of fixed on/off length.
//  Events that arrive during a blink are queued in a saturating pending counter and replayed
//  as separate blinks. Sits between the event sources and the board LED pins.
// PARAMETERS
//  ON_CYCLES   4   LED-high cycles per blink (>=1; e.g. 12_500_000 on hardware)
//  OFF_CYCLES  2   mandatory LED-low gap after each blink (>=1)
//  CNT_W       24  blink timer width; must hold max(ON_CYCLES,OFF_CYCLES)-1
//  PEND_W      2   pending-event counter width; max queued = 2**PEND_W-1
// PORTS
//  clk       in   1       clock
//  rst_p     in   1       reset, asynchronous, active-high
//  evt_in    in   1       event strobe; each high cycle = one event
//  clear     in   1       sync clear: drop queue, abort blink, clear overflow
//  led_out   out  1       registered LED drive
//  busy      out  1       1 when state!=IDLE or pending!=0
//  pending   out  PEND_W  queued events not yet started
//  overflow  out  1       sticky: an event was dropped at saturation
// BEHAVIOUR
//  - Reset: state=IDLE, timer=0, pending=0, led_out=0, busy=0, overflow=0. Reset mid-blink
//    forces LED low immediately (async); queued events are lost.
//  - FSM states IDLE, ON, GAP; timer counts 0..N-1 in ON/GAP and is 0 in IDLE.
//    IDLE: pending!=0 -> ON, pending-1, timer=0, led_out<=1.
//    ON:   led_out=1; at timer==ON_CYCLES-1 -> GAP, timer=0, led_out<=0.
//    GAP:  led_out=0; at timer==OFF_CYCLES-1 -> ON if pending!=0 (dequeue as in IDLE),
//          else IDLE.
//  - Latency: evt_in sampled at edge N -> pending=1 after N; led_out high after N+1.
//    LED high exactly ON_CYCLES cycles, then low at least OFF_CYCLES cycles.
//  - Blink period under back-to-back load = ON_CYCLES+OFF_CYCLES (no idle cycle).
//  - Pending update per edge: +1 on accepted evt, -1 on dequeue; both together -> unchanged.
//  - Saturation: evt_in while pending==max and no dequeue that edge -> event dropped,
//    overflow<=1 (sticky); pending stays at max. evt with simultaneous dequeue is never dropped.
//  - clear (priority over evt_in and FSM): next edge state=IDLE, timer=0, led_out=0,
//    pending=0, overflow=0; evt_in in the same cycle is discarded.
//  - busy and pending are registered/derived from registers; no combinational path
//    from evt_in to any output.
// TESTING (ON_CYCLES=4, OFF_CYCLES=2, PEND_W=2)
//  1 reset, evt_in=1 sampled at edge 10 only -> pending=1 after 10, led_out=1 after edges
//    11..14 (4 cycles), 0 after 15; busy=0 from edge 17 (after GAP).
//  2 evt_in high for edges 10,11,12 -> exactly 3 blinks, rising edges 6 cycles apart,
//    pending peaks at 2, overflow=0.
//  3 evt_in high for edges 10..14 (5 events) -> pending reaches 3, one event dropped,
//    overflow=1, exactly 4 blinks, overflow stays 1 afterwards.
//  4 mid-blink (2 cycles into ON, pending=2): assert clear 1 cycle -> led_out=0, pending=0,
//    overflow=0, busy=0 next edge; no further blinks.
//  5 rst_p asserted asynchronously between edges during ON -> led_out drops before next edge;
//    after release, single event behaves as scenario 1.
//  6 evt_in and clear high in same cycle -> clear wins, pending=0, no blink.

Source files
------------

// File: rtl/led_event_blinker.sv
// Turns 1-clk event strobes into LED blinks of fixed on/off length.
// Events that arrive during a blink wait in a saturating queue and are replayed one per blink.
module led_event_blinker #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int CNT_W      = 24,
  parameter int PEND_W     = 2
) (
  input  logic              clk,
  input  logic              rst_p,
  input  logic              evt_in,
  input  logic              clear,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  timer, timer_n;
  logic [PEND_W-1:0] pend_n;
  logic              led_n, ovf_n, busy_n;
  logic              dequeue, accept, drop;

  // Next-state, queue and flag computation; everything below is registered.
  always_comb begin
    dequeue = 1'b0;
    case (state)
      IDLE:    dequeue = (pending != {PEND_W{1'b0}});
      GAP:     dequeue = (timer == OFF_LAST) && (pending != {PEND_W{1'b0}});
      default: dequeue = 1'b0;
    endcase

    // A dequeue on the same edge frees a slot, so a full queue can still accept.
    accept  = evt_in && ((pending != PEND_MAX) || dequeue);
    drop    = evt_in && !accept;

    state_n = state;
    timer_n = timer;
    led_n   = led_out;
    pend_n  = pending;
    ovf_n   = overflow;

    if (clear) begin
      state_n = IDLE;
      timer_n = {CNT_W{1'b0}};
      led_n   = 1'b0;
      pend_n  = {PEND_W{1'b0}};
      ovf_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer_n = {CNT_W{1'b0}};
          if (dequeue) begin
            state_n = ON;
            led_n   = 1'b1;
          end else begin
            state_n = IDLE;
            led_n   = 1'b0;
          end
        end
        ON: begin
          if (timer == ON_LAST) begin
            state_n = GAP;
            timer_n = {CNT_W{1'b0}};
            led_n   = 1'b0;
          end else begin
            timer_n = timer + CNT_W'(1);
            led_n   = 1'b1;
          end
        end
        GAP: begin
          if (timer == OFF_LAST) begin
            timer_n = {CNT_W{1'b0}};
            if (dequeue) begin
              state_n = ON;
              led_n   = 1'b1;
            end else begin
              state_n = IDLE;
              led_n   = 1'b0;
            end
          end else begin
            timer_n = timer + CNT_W'(1);
            led_n   = 1'b0;
          end
        end
        default: begin
          state_n = IDLE;
          timer_n = {CNT_W{1'b0}};
          led_n   = 1'b0;
        end
      endcase

      case ({accept, dequeue})
        2'b10:   pend_n = pending + PEND_W'(1);
        2'b01:   pend_n = pending - PEND_W'(1);
        default: pend_n = pending;
      endcase

      ovf_n = overflow | drop;
    end

    busy_n = (state_n != IDLE) || (pend_n != {PEND_W{1'b0}});
  end

  // State, timer and all outputs; reset forces the LED low without waiting for an edge.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state    <= IDLE;
      timer    <= {CNT_W{1'b0}};
      pending  <= {PEND_W{1'b0}};
      led_out  <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      pending  <= pend_n;
      led_out  <= led_n;
      busy     <= busy_n;
      overflow <= ovf_n;
    end
  end

endmodule

// File: tb/tb_led_event_blinker.sv
// Self-checking bench for led_event_blinker (ON_CYCLES=4, OFF_CYCLES=2, PEND_W=2).
module tb_led_event_blinker;

  logic       clk = 1'b0;
  logic       rst_p = 1'b1;
  logic       evt_in = 1'b0;
  logic       clear = 1'b0;
  logic       led_out, busy, overflow;
  logic [1:0] pending;

  int checks = 0;
  int failures = 0;

  led_event_blinker #(
    .ON_CYCLES(4), .OFF_CYCLES(2), .CNT_W(24), .PEND_W(2)
  ) dut (
    .clk(clk), .rst_p(rst_p), .evt_in(evt_in), .clear(clear),
    .led_out(led_out), .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       evt;
    logic       clr;
    logic       led;
    logic [1:0] pend;
    logic       bsy;
    logic       ovf;
  } vec_t;

  vec_t vec [0:11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    evt_in = 1'b0;
    clear  = 1'b0;
    rst_p  = 1'b1;
    @(negedge clk);
    rst_p  = 1'b0;
  endtask

  // One vector per clock: drive at negedge, compare just after the following posedge.
  task automatic apply_vectors(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      evt_in = vec[i].evt;
      clear  = vec[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d].led", tag, i), int'(led_out), int'(vec[i].led));
      check($sformatf("%s[%0d].pend", tag, i), int'(pending), int'(vec[i].pend));
      check($sformatf("%s[%0d].busy", tag, i), int'(busy), int'(vec[i].bsy));
      check($sformatf("%s[%0d].ovf", tag, i), int'(overflow), int'(vec[i].ovf));
    end
    evt_in = 1'b0;
    clear  = 1'b0;
  endtask

  // Drives n back-to-back events, then runs until idle, counting blinks and rise spacing.
  task automatic run_burst(input int n, output int rises, output int peak,
                           output int gaps_bad, output int timed_out);
    int   last_rise;
    logic prev;
    prev = 1'b0; rises = 0; peak = 0; gaps_bad = 0; timed_out = 1; last_rise = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (led_out && !prev) begin
        if (last_rise >= 0 && (cyc - last_rise) != 6) gaps_bad++;
        last_rise = cyc;
        rises++;
      end
      prev = led_out;
      if (int'(pending) > peak) peak = int'(pending);
      if (cyc > n + 1 && !busy && !led_out) begin
        timed_out = 0;
        break;
      end
      evt_in = (cyc < n);
    end
    evt_in = 1'b0;
  endtask

  int rises, peak, gaps_bad, timed_out, highs;

  initial begin
    // scenario 1: single event at the first edge
    vec[0]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
    vec[1]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
    vec[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    // scenario 6: event and clear together, clear wins
    vec[9]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    vec[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vec[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

    #12;
    check("rst.led", int'(led_out), 0);
    check("rst.pend", int'(pending), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.ovf", int'(overflow), 0);
    do_reset();

    apply_vectors(0, 8, "s1");
    apply_vectors(9, 11, "s6");

    // scenario 2: three consecutive events
    do_reset();
    run_burst(3, rises, peak, gaps_bad, timed_out);
    check("s2.done", timed_out, 0);
    check("s2.blinks", rises, 3);
    check("s2.peak", peak, 2);
    check("s2.spacing", gaps_bad, 0);
    check("s2.ovf", int'(overflow), 0);

    // scenario 3: five consecutive events, one dropped at saturation
    do_reset();
    run_burst(5, rises, peak, gaps_bad, timed_out);
    check("s3.done", timed_out, 0);
    check("s3.blinks", rises, 4);
    check("s3.peak", peak, 3);
    check("s3.spacing", gaps_bad, 0);
    repeat (5) @(negedge clk);
    check("s3.ovf_sticky", int'(overflow), 1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("s3.ovf_cleared", int'(overflow), 0);

    // scenario 4: clear two cycles into ON with two events queued behind
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      evt_in = 1'b1;
    end
    @(posedge clk); #1;
    check("s4.pend_before", int'(pending), 2);
    check("s4.led_before", int'(led_out), 1);
    @(negedge clk);
    evt_in = 1'b0;
    clear  = 1'b1;
    @(posedge clk); #1;
    check("s4.led", int'(led_out), 0);
    check("s4.pend", int'(pending), 0);
    check("s4.busy", int'(busy), 0);
    check("s4.ovf", int'(overflow), 0);
    @(negedge clk);
    clear = 1'b0;
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (led_out) highs++;
    end
    check("s4.no_more_blinks", highs, 0);

    // scenario 5: asynchronous reset during ON, then a normal single event
    do_reset();
    @(negedge clk);
    evt_in = 1'b1;
    @(negedge clk);
    evt_in = 1'b0;
    @(posedge clk); #3;
    check("s5.led_on", int'(led_out), 1);
    rst_p = 1'b1;
    #1;
    check("s5.led_async", int'(led_out), 0);
    check("s5.pend_async", int'(pending), 0);
    check("s5.busy_async", int'(busy), 0);
    @(negedge clk);
    rst_p = 1'b0;
    apply_vectors(0, 8, "s5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
